// File: rtl/himax_cap_pkg.sv
// rtl/himax_cap_pkg.sv - shared types and helpers for the Himax pixel capture front end
package himax_cap_pkg;

  typedef enum logic [1:0] {
    DECIM_1X = 2'd0,
    DECIM_2X = 2'd1,
    DECIM_4X = 2'd2,
    DECIM_8X = 2'd3
  } decim_e;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACTIVE = 2'd2,
    S_SKIP   = 2'd3
  } state_e;

  // Sensor bus beats needed to build one 8-bit pixel.
  function automatic int beats(input int pxw);
    return 8 / pxw;
  endfunction

endpackage

// File: rtl/himax_px_capture_if.sv
// rtl/himax_px_capture_if.sv - captured pixel stream with frame/line markers
interface himax_px_capture_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sof;
  logic       out_eol;

  modport master (output out_data, output out_valid, output out_sof, output out_eol, input out_ready);
  modport slave  (input out_data, input out_valid, input out_sof, input out_eol, output out_ready);
endinterface

// File: rtl/himax_px_packer.sv
// rtl/himax_px_packer.sv - gathers sensor beats into 8-bit pixels, one registered strobe per pixel
module himax_px_packer
  import himax_cap_pkg::*;
#(
  parameter int PXW       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           lv,
  input  logic [PXW-1:0] pxd,
  output logic [7:0]     pix,
  output logic           pix_stb
);

  localparam int NB = beats(PXW);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  logic [BW-1:0] beat_q, beat_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    pix_q, pix_d;
  logic          stb_q, stb_d;

  always_comb begin
    beat_d  = beat_q;
    shift_d = shift_q;
    pix_d   = pix_q;
    stb_d   = 1'b0;
    if (!lv) begin
      // A line ending mid-pixel drops the partial beats.
      beat_d = '0;
    end else begin
      if (MSB_FIRST) begin
        shift_d = (shift_q << PXW) | 8'(pxd);
      end else begin
        shift_d = (shift_q >> PXW) | (8'(pxd) << (8 - PXW));
      end
      if (beat_q == BW'(NB - 1)) begin
        beat_d = '0;
        pix_d  = shift_d;
        stb_d  = 1'b1;
      end else begin
        beat_d = BW'(beat_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      shift_q <= '0;
      pix_q   <= '0;
      stb_q   <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      shift_q <= shift_d;
      pix_q   <= pix_d;
      stb_q   <= stb_d;
    end
  end

  assign pix     = pix_q;
  assign pix_stb = stb_q;

endmodule

// File: rtl/himax_px_capture.sv
// rtl/himax_px_capture.sv - Himax sensor capture: packing, ROI crop, decimation, stream output and frame stats
module himax_px_capture
  import himax_cap_pkg::*;
#(
  parameter int PXW       = 4,
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 px_fv,
  input  logic                 px_lv,
  input  logic [PXW-1:0]       pxd,
  input  logic                 enable,
  input  logic [1:0]           decim,
  input  logic [XW-1:0]        roi_x0,
  input  logic [XW-1:0]        roi_x1,
  input  logic [YW-1:0]        roi_y0,
  input  logic [YW-1:0]        roi_y1,
  himax_px_capture_if.master   out_if,
  output logic                 frame_done,
  output logic [15:0]          frame_cnt,
  output logic                 overflow,
  input  logic                 overflow_clr
);

  logic           fv_q, lv_q, fv_prev_q, lv_prev_q, armed_q;
  logic [PXW-1:0] pxd_q;
  state_e         state_q, state_d;
  decim_e         decim_q, decim_d;
  logic [XW-1:0]  x0_q, x0_d, x1_q, x1_d, x_q, x_d;
  logic [YW-1:0]  y0_q, y0_d, y1_q, y1_d, y_q, y_d;
  logic           sof_pend_q, sof_pend_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic           done_q, done_d, ovf_q, ovf_d;
  logic [15:0]    fcnt_q, fcnt_d;

  logic [7:0]     pix;
  logic           pix_stb;
  logic           lv_eff, line_end, fv_rise, fv_fall;
  logic           in_win, aligned, accept, eol_hit;
  logic [XW-1:0]  x_off, x_mask;
  logic [YW-1:0]  y_off, y_mask;
  logic [XW+3:0]  x_step;

  // Frame valid dropping also terminates any line still in progress.
  assign lv_eff   = lv_q & fv_q;
  assign line_end = lv_prev_q & ~lv_eff;
  assign fv_rise  = fv_q & ~fv_prev_q;
  assign fv_fall  = ~fv_q & fv_prev_q;

  himax_px_packer #(.PXW(PXW), .MSB_FIRST(MSB_FIRST)) u_packer (
    .clk     (clk),
    .rst     (rst),
    .lv      (lv_eff),
    .pxd     (pxd_q),
    .pix     (pix),
    .pix_stb (pix_stb)
  );

  always_comb begin
    x_off   = x_q - x0_q;
    y_off   = y_q - y0_q;
    x_mask  = ~({XW{1'b1}} << decim_q);
    y_mask  = ~({YW{1'b1}} << decim_q);
    x_step  = {4'b0, x_q} + ((XW + 4)'(1) << decim_q);
    eol_hit = x_step > {4'b0, x1_q};
    in_win  = (x_q >= x0_q) && (x_q <= x1_q) && (y_q >= y0_q) && (y_q <= y1_q);
    aligned = ((x_off & x_mask) == '0) && ((y_off & y_mask) == '0);
    accept  = (state_q == S_ACTIVE) && pix_stb && in_win && aligned;
  end

  always_comb begin
    state_d    = state_q;
    decim_d    = decim_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    sof_pend_d = sof_pend_q;
    done_d     = 1'b0;
    fcnt_d     = fcnt_q;
    unique case (state_q)
      S_SYNC: begin
        // armed_q masks the reset value of fv_q so a frame already running at reset is skipped.
        if (armed_q && !fv_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (fv_rise) begin
          decim_d    = decim_e'(decim);
          x0_d       = roi_x0;
          x1_d       = roi_x1;
          y0_d       = roi_y0;
          y1_d       = roi_y1;
          sof_pend_d = 1'b1;
          state_d    = enable ? S_ACTIVE : S_SKIP;
        end
      end
      S_ACTIVE: begin
        if (fv_fall) begin
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      S_SKIP: begin
        if (fv_fall) state_d = S_IDLE;
      end
      default: state_d = S_SYNC;
    endcase
    if (accept) sof_pend_d = 1'b0;
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (line_end) x_d = '0;
    else if (pix_stb && (x_q != '1)) x_d = x_q + 1'b1;
    if (fv_rise) y_d = '0;
    else if (line_end && (y_q != '1)) y_d = y_q + 1'b1;
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    ovf_d   = ovf_q;
    if (accept && (!valid_q || out_if.out_ready)) begin
      data_d  = pix;
      sof_d   = sof_pend_q;
      eol_d   = eol_hit;
      valid_d = 1'b1;
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
    // The sensor cannot be stalled: a pixel arriving behind a held one is lost.
    if (accept && valid_q && !out_if.out_ready) ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q       <= 1'b0;
      lv_q       <= 1'b0;
      pxd_q      <= '0;
      fv_prev_q  <= 1'b0;
      lv_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      state_q    <= S_SYNC;
      decim_q    <= DECIM_1X;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sof_pend_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      done_q     <= 1'b0;
      fcnt_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      fv_q       <= px_fv;
      lv_q       <= px_lv;
      pxd_q      <= pxd;
      fv_prev_q  <= fv_q;
      lv_prev_q  <= lv_eff;
      armed_q    <= 1'b1;
      state_q    <= state_d;
      decim_q    <= decim_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sof_pend_q <= sof_pend_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      done_q     <= done_d;
      fcnt_q     <= fcnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_sof   = sof_q;
  assign out_if.out_eol   = eol_q;
  assign frame_done       = done_q;
  assign frame_cnt        = fcnt_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_himax_px_capture.sv
// tb/tb_himax_px_capture.sv - self-checking bench for himax_px_capture (4-bit and 8-bit bus builds)
module tb_himax_px_capture;

  typedef struct {
    int w; int h; int x0; int x1; int y0; int y1; int d; int n;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
  } px_t;

  logic        clk = 1'b0;
  logic        rst, px_fv, px_lv, enable, overflow_clr, rdy;
  logic [3:0]  pxd4;
  logic [7:0]  pxd8;
  logic [1:0]  decim;
  logic [9:0]  roi_x0, roi_x1, roi_y0, roi_y1;
  logic        fd4, fd8, ovf4, ovf8;
  logic [15:0] fcnt4, fcnt8;

  int checks = 0;
  int failures = 0;
  int fd4_n = 0;
  int fd8_n = 0;
  int v8_n = 0;
  int exp_fcnt = 0;
  px_t got[$];
  logic [7:0] pix_mem [0:15][0:15];
  vec_t tbl [6];

  himax_px_capture_if ifc4 ();
  himax_px_capture_if ifc8 ();
  assign ifc4.out_ready = rdy;
  assign ifc8.out_ready = 1'b1;

  always #5 clk = ~clk;

  himax_px_capture #(.PXW(4), .XW(10), .YW(10), .MSB_FIRST(1'b1)) u4 (
    .clk(clk), .rst(rst), .px_fv(px_fv), .px_lv(px_lv), .pxd(pxd4),
    .enable(enable), .decim(decim),
    .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
    .out_if(ifc4.master), .frame_done(fd4), .frame_cnt(fcnt4),
    .overflow(ovf4), .overflow_clr(overflow_clr)
  );

  himax_px_capture #(.PXW(8), .XW(10), .YW(10), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .rst(rst), .px_fv(px_fv), .px_lv(px_lv), .pxd(pxd8),
    .enable(enable), .decim(decim),
    .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
    .out_if(ifc8.master), .frame_done(fd8), .frame_cnt(fcnt8),
    .overflow(ovf8), .overflow_clr(overflow_clr)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc4.out_valid && ifc4.out_ready) got.push_back({ifc4.out_data, ifc4.out_sof, ifc4.out_eol});
      if (fd4) fd4_n = fd4_n + 1;
      if (fd8) fd8_n = fd8_n + 1;
      if (ifc8.out_valid) v8_n = v8_n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pix();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        pix_mem[y][x] = 8'($urandom);
  endtask

  task automatic apply_cfg(input vec_t v);
    roi_x0 = v.x0[9:0];
    roi_x1 = v.x1[9:0];
    roi_y0 = v.y0[9:0];
    roi_y1 = v.y1[9:0];
    decim  = v.d[1:0];
  endtask

  // Nibbles go out high half first; pixel x of row r lives at pix_mem[r][x].
  task automatic drive_lines(input int lv_cyc, input int rows);
    for (int r = 0; r < rows; r++) begin
      px_lv = 1'b1;
      for (int i = 0; i < lv_cyc; i++) begin
        pxd4 = (i % 2 == 0) ? pix_mem[r][i/2][7:4] : pix_mem[r][i/2][3:0];
        pxd8 = 8'($urandom);
        tick();
      end
      px_lv = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic drive_frame(input int w, input int h, input logic en);
    enable = en;
    px_fv = 1'b1;
    repeat (3) tick();
    drive_lines(2 * w, h);
    px_fv = 1'b0;
    repeat (6) tick();
  endtask

  // Expected stream straight from the ROI/decimation rules, compared with what was transferred.
  task automatic check_frame(input vec_t v, input int rd, input int fd_base);
    px_t exp[$];
    px_t p;
    bit first = 1'b1;
    int n;
    int step = 1 << v.d;
    for (int y = 0; y < v.h; y++)
      for (int x = 0; x < v.w; x++)
        if (x >= v.x0 && x <= v.x1 && y >= v.y0 && y <= v.y1 &&
            ((x - v.x0) % step) == 0 && ((y - v.y0) % step) == 0) begin
          p.d = pix_mem[y][x];
          p.s = first;
          p.e = (x + step > v.x1);
          exp.push_back(p);
          first = 1'b0;
        end
    n = got.size() - rd;
    if (v.n >= 0) chk("table_px_count", n, v.n);
    chk("px_count", n, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < n) begin
        chk("px_data", got[rd+i].d, exp[i].d);
        chk("px_sof", got[rd+i].s, exp[i].s);
        chk("px_eol", got[rd+i].e, exp[i].e);
      end
    end
    chk("frame_done_pulses", fd4_n - fd_base, 1);
    chk("frame_cnt", fcnt4, exp_fcnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t v, full;
    int rd, fdb, v8b;
    full = '{16, 16, 0, 1023, 0, 1023, 0, -1};
    tbl[0] = '{8, 4, 2, 5, 1, 3, 1, 4};
    tbl[1] = '{6, 3, 0, 1023, 0, 1023, 0, 18};
    tbl[2] = '{8, 4, 0, 7, 0, 3, 2, 2};
    tbl[3] = '{8, 2, 5, 3, 0, 1, 0, 0};
    tbl[4] = '{10, 5, 1, 9, 1, 4, 3, 2};
    tbl[5] = '{4, 4, 3, 3, 2, 2, 0, 1};

    rst = 1'b1; px_fv = 1'b1; px_lv = 1'b0; pxd4 = '0; pxd8 = '0;
    enable = 1'b1; overflow_clr = 1'b0; rdy = 1'b1;
    apply_cfg(full);
    fill_pix();
    repeat (4) tick();
    chk("rst_out_valid", ifc4.out_valid, 0);
    chk("rst_frame_done", fd4, 0);
    chk("rst_frame_cnt", fcnt4, 0);
    chk("rst_overflow", ovf4, 0);
    chk("rst_frame_cnt8", fcnt8, 0);

    // Reset released mid-frame: that frame must be ignored entirely.
    rst = 1'b0;
    drive_lines(8, 2);
    px_fv = 1'b0;
    repeat (6) tick();
    chk("midframe_rst_pixels", got.size(), 0);
    chk("midframe_rst_done", fd4_n, 0);
    chk("midframe_rst_cnt", fcnt4, 0);

    // Nibbles A,5,3,C: pixel latency and packing order.
    fdb = fd4_n;
    px_fv = 1'b1;
    repeat (3) tick();
    px_lv = 1'b1; pxd4 = 4'hA; tick();
    pxd4 = 4'h5; tick();
    chk("lat_edge0_valid", ifc4.out_valid, 0);
    pxd4 = 4'h3; tick();
    chk("lat_edge1_valid", ifc4.out_valid, 0);
    pxd4 = 4'hC; tick();
    chk("lat_edge2_valid", ifc4.out_valid, 1);
    chk("lat_px0_data", ifc4.out_data, 8'hA5);
    chk("lat_px0_sof", ifc4.out_sof, 1);
    px_lv = 1'b0; tick();
    chk("lat_px0_gone", ifc4.out_valid, 0);
    tick();
    chk("lat_px1_valid", ifc4.out_valid, 1);
    chk("lat_px1_data", ifc4.out_data, 8'h3C);
    chk("lat_px1_sof", ifc4.out_sof, 0);
    px_fv = 1'b0;
    repeat (6) tick();
    exp_fcnt = exp_fcnt + 1;
    chk("lat_done", fd4_n - fdb, 1);
    chk("lat_frame_cnt", fcnt4, exp_fcnt);

    for (int t = 0; t < 6; t++) begin
      fill_pix();
      apply_cfg(tbl[t]);
      rd = got.size(); fdb = fd4_n;
      drive_frame(tbl[t].w, tbl[t].h, 1'b1);
      exp_fcnt = exp_fcnt + 1;
      check_frame(tbl[t], rd, fdb);
    end

    for (int t = 0; t < 16; t++) begin
      fill_pix();
      v.w  = $urandom_range(2, 12);
      v.h  = $urandom_range(1, 6);
      v.x0 = $urandom_range(0, 13);
      v.x1 = $urandom_range(0, 15);
      v.y0 = $urandom_range(0, 5);
      v.y1 = $urandom_range(0, 7);
      v.d  = $urandom_range(0, 3);
      v.n  = -1;
      apply_cfg(v);
      rd = got.size(); fdb = fd4_n;
      drive_frame(v.w, v.h, 1'b1);
      exp_fcnt = exp_fcnt + 1;
      check_frame(v, rd, fdb);
    end

    // Stalled sink: first pixel held, the next two lost, overflow sticky until cleared.
    fill_pix();
    apply_cfg(full);
    rdy = 1'b0;
    rd = got.size(); fdb = fd4_n;
    drive_frame(3, 1, 1'b1);
    exp_fcnt = exp_fcnt + 1;
    chk("stall_overflow", ovf4, 1);
    chk("stall_valid", ifc4.out_valid, 1);
    chk("stall_held_data", ifc4.out_data, pix_mem[0][0]);
    chk("stall_held_sof", ifc4.out_sof, 1);
    rdy = 1'b1;
    tick();
    chk("stall_drain_valid", ifc4.out_valid, 0);
    chk("stall_transfers", got.size() - rd, 1);
    if (got.size() > rd) chk("stall_xfer_data", got[rd].d, pix_mem[0][0]);
    chk("stall_ovf_kept", ovf4, 1);
    overflow_clr = 1'b1; tick();
    overflow_clr = 1'b0;
    chk("ovf_cleared", ovf4, 0);
    chk("stall_frame_cnt", fcnt4, exp_fcnt);

    // Capture disabled at frame start; raising enable mid-frame changes nothing.
    fill_pix();
    rd = got.size(); fdb = fd4_n;
    fork
      drive_frame(4, 2, 1'b0);
      begin
        repeat (8) tick();
        enable = 1'b1;
      end
    join
    chk("skip_pixels", got.size() - rd, 0);
    chk("skip_done", fd4_n - fdb, 0);
    chk("skip_frame_cnt", fcnt4, exp_fcnt);
    v = full; v.w = 4; v.h = 2;
    rd = got.size(); fdb = fd4_n;
    drive_frame(4, 2, 1'b1);
    exp_fcnt = exp_fcnt + 1;
    check_frame(v, rd, fdb);

    // Truncated last line: fv drops with lv still high after two whole pixels.
    fill_pix();
    rd = got.size(); fdb = fd4_n;
    px_fv = 1'b1;
    repeat (3) tick();
    drive_lines(8, 1);
    px_lv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pxd4 = (i % 2 == 0) ? pix_mem[1][i/2][7:4] : pix_mem[1][i/2][3:0];
      tick();
    end
    px_fv = 1'b0;
    repeat (3) tick();
    px_lv = 1'b0;
    repeat (6) tick();
    exp_fcnt = exp_fcnt + 1;
    chk("trunc_pixels", got.size() - rd, 6);
    if (got.size() > 0) chk("trunc_last_data", got[got.size()-1].d, pix_mem[1][1]);
    chk("trunc_done", fd4_n - fdb, 1);
    chk("trunc_frame_cnt", fcnt4, exp_fcnt);

    // 8-bit bus, odd beat count per line, empty column window.
    fill_pix();
    v = full; v.x0 = 5; v.x1 = 3;
    apply_cfg(v);
    rd = got.size(); fdb = fd8_n; v8b = v8_n;
    enable = 1'b1;
    px_fv = 1'b1;
    repeat (3) tick();
    drive_lines(5, 2);
    px_fv = 1'b0;
    repeat (6) tick();
    exp_fcnt = exp_fcnt + 1;
    chk("px8_no_pixels", v8_n - v8b, 0);
    chk("px8_done", fd8_n - fdb, 1);
    chk("px8_frame_cnt", fcnt8, exp_fcnt);
    chk("px4_empty_roi_pixels", got.size() - rd, 0);
    chk("px4_frame_cnt", fcnt4, exp_fcnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
